// File: rtl/mem_load_arbiter.sv
// mem_load_arbiter: shares the program/data RAM between the CPU datapath and
// an external byte-stream loader. A load halts the CPU at an instruction
// boundary and streams bytes into RAM from a base address with auto-increment.
// It then hands the RAM back and pulses a CPU restart.
module mem_load_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int HALT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // CPU side
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_din,
  input  logic              cpu_mem_we,
  output logic [DATA_W-1:0] cpu_mem_dout,
  input  logic              cpu_at_boundary,
  output logic              cpu_halt,
  output logic              cpu_restart,
  // Loader side
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              err_timeout,
  output logic              err_overflow,
  // RAM macro side (asynchronous read)
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int TIMER_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(HALT_TIMEOUT - 1);
  // ld_count value just before the beat that fills the whole RAM
  localparam logic [ADDR_W:0]    COUNT_FULL = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_LOAD,
    S_RESTART
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_overflow_q, err_overflow_d;

  // Next-state and counter update for the load sequencer
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    addr_d         = addr_q;
    timer_d        = timer_q;
    count_d        = count_q;
    err_timeout_d  = err_timeout_q;
    err_overflow_d = err_overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          addr_d         = ld_base;
          count_d        = '0;
          timer_d        = '0;
          err_timeout_d  = 1'b0;
          err_overflow_d = 1'b0;
          state_d        = S_HALT_WAIT;
        end
      end

      S_HALT_WAIT: begin
        if (cpu_at_boundary) begin
          state_d = S_LOAD;
        end else if (timer_q == TIMER_MAX) begin
          // CPU never reached a boundary: give up without touching RAM
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_LOAD: begin
        if (ld_valid) begin
          addr_d  = addr_q + 1'b1;  // wraps naturally at 2**ADDR_W
          count_d = count_q + 1'b1;
          if (ld_last) begin
            state_d = S_RESTART;
          end else if (count_q == COUNT_FULL) begin
            // This beat filled every location; stop before overwriting
            err_overflow_d = 1'b1;
            state_d        = S_RESTART;
          end
        end
      end

      S_RESTART: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      timer_q        <= '0;
      count_q        <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      timer_q        <= timer_d;
      count_q        <= count_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Output decode: the RAM mux is combinational so the CPU sees no added latency
  assign ld_busy      = (state_q != S_IDLE);
  assign cpu_halt     = (state_q != S_IDLE);
  assign cpu_restart  = (state_q == S_RESTART);
  assign ld_ready     = (state_q == S_LOAD);
  assign ld_count     = count_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

  assign ram_addr     = (state_q == S_LOAD) ? addr_q  : cpu_mem_addr;
  assign ram_din      = (state_q == S_LOAD) ? ld_data : cpu_mem_din;
  // CPU strobes outside IDLE are dropped, not deferred
  assign ram_we       = (state_q == S_IDLE) ? cpu_mem_we :
                        (state_q == S_LOAD) ? ld_valid   : 1'b0;
  assign cpu_mem_dout = (state_q == S_LOAD) ? '0 : ram_dout;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Directed testbench for mem_load_arbiter with a behavioural RAM and a
// write scoreboard: every expected RAM write is queued when stimulus is
// driven and matched against the DUT's ram_we/ram_addr/ram_din.
module tb_mem_load_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [DATA_W-1:0] cpu_mem_din;
  logic              cpu_mem_we;
  logic [DATA_W-1:0] cpu_mem_dout;
  logic              cpu_at_boundary;
  logic              cpu_halt;
  logic              cpu_restart;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;
  logic [ADDR_W:0]   ld_count;
  logic              err_timeout;
  logic              err_overflow;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  mem_load_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_dout(cpu_mem_dout), .cpu_at_boundary(cpu_at_boundary),
    .cpu_halt(cpu_halt), .cpu_restart(cpu_restart),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_count(ld_count),
    .err_timeout(err_timeout), .err_overflow(err_overflow),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM macro: synchronous write, asynchronous read
  logic [DATA_W-1:0] mem [2**ADDR_W];
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
  always @(posedge clk) if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each observed RAM write must match the oldest queued expectation
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_din), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One-cycle ld_start; returns with the DUT in HALT_WAIT
  task automatic start_load(input logic [ADDR_W-1:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
  endtask

  // One-cycle boundary indication; returns with the DUT in LOAD
  task automatic boundary();
    cpu_at_boundary = 1'b1;
    tick();
    cpu_at_boundary = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic last, input logic [ADDR_W-1:0] a);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    expect_write(a, d);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_mem_addr = a;
    #1;
    check(tag, 32'(cpu_mem_dout), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cpu_mem_addr = '0; cpu_mem_din = '0; cpu_mem_we = 1'b0; cpu_at_boundary = 1'b0;
    ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_halt",     32'(cpu_halt),     32'd0);
    check("rst_restart",  32'(cpu_restart),  32'd0);
    check("rst_ready",    32'(ld_ready),     32'd0);
    check("rst_busy",     32'(ld_busy),      32'd0);
    check("rst_we",       32'(ram_we),       32'd0);
    check("rst_count",    32'(ld_count),     32'd0);
    check("rst_err_to",   32'(err_timeout),  32'd0);
    check("rst_err_ov",   32'(err_overflow), 32'd0);
    rst = 1'b0;
    tick();

    // CPU write in IDLE lands in the same cycle
    cpu_mem_addr = 8'h05; cpu_mem_din = 8'h77; cpu_mem_we = 1'b1;
    expect_write(8'h05, 8'h77);
    #1;
    check("idle_we_pass",   32'(ram_we),   32'd1);
    check("idle_addr_pass", 32'(ram_addr), 32'h05);
    tick();
    cpu_mem_we = 1'b0;
    cpu_read("idle_readback", 8'h05, 8'h77);

    // Normal load: boundary three cycles after ld_start
    start_load(8'h10);
    check("hw_halt", 32'(cpu_halt), 32'd1);
    check("hw_busy", 32'(ld_busy),  32'd1);
    cpu_mem_we = 1'b1; cpu_mem_addr = 8'h06; cpu_mem_din = 8'h55;
    #1;
    check("hw_cpu_we_dropped", 32'(ram_we), 32'd0);
    tick();
    cpu_mem_we = 1'b0;
    tick();
    boundary();
    check("load_ready", 32'(ld_ready),     32'd1);
    check("load_dout0", 32'(cpu_mem_dout), 32'd0);
    beat(8'hA1, 1'b0, 8'h10);
    beat(8'hB2, 1'b0, 8'h11);
    beat(8'hC3, 1'b1, 8'h12);
    check("rs_restart", 32'(cpu_restart), 32'd1);
    check("rs_halt",    32'(cpu_halt),    32'd1);
    check("rs_we",      32'(ram_we),      32'd0);
    tick();
    check("post_restart", 32'(cpu_restart), 32'd0);
    check("post_halt",    32'(cpu_halt),    32'd0);
    check("norm_count",   32'(ld_count),    32'd3);
    cpu_read("norm_rd10", 8'h10, 8'hA1);
    cpu_read("norm_rd11", 8'h11, 8'hB2);
    cpu_read("norm_rd12", 8'h12, 8'hC3);

    // Backpressure: valid pattern 1,0,0,1; CPU write attempted during LOAD
    start_load(8'h20);
    boundary();
    beat(8'h11, 1'b0, 8'h20);
    cpu_mem_we = 1'b1; cpu_mem_addr = 8'h05; cpu_mem_din = 8'h99;
    #1;
    check("gap_we0",    32'(ram_we),   32'd0);
    check("gap_ready",  32'(ld_ready), 32'd1);
    tick();
    cpu_mem_we = 1'b0;
    #1;
    check("gap_we1",    32'(ram_we),   32'd0);
    tick();
    beat(8'h22, 1'b1, 8'h21);
    tick();
    check("gap_count",  32'(ld_count), 32'd2);
    cpu_read("gap_rd20",     8'h20, 8'h11);
    cpu_read("gap_rd21",     8'h21, 8'h22);
    cpu_read("cpu_wr_kept",  8'h05, 8'h77);

    // Address wrap
    start_load(8'hFE);
    boundary();
    beat(8'hE0, 1'b0, 8'hFE);
    beat(8'hE1, 1'b0, 8'hFF);
    beat(8'hE2, 1'b0, 8'h00);
    beat(8'hE3, 1'b1, 8'h01);
    tick();
    check("wrap_count", 32'(ld_count),     32'd4);
    check("wrap_err_ov", 32'(err_overflow), 32'd0);
    cpu_read("wrap_rdff", 8'hFF, 8'hE1);
    cpu_read("wrap_rd00", 8'h00, 8'hE2);

    // Halt timeout: no boundary ever arrives
    start_load(8'h40);
    for (int i = 0; i < 15; i++) begin
      check("to_restart", 32'(cpu_restart), 32'd0);
      tick();
    end
    check("to_not_yet", 32'(err_timeout), 32'd0);
    check("to_busy",    32'(ld_busy),     32'd1);
    tick();
    check("to_err",      32'(err_timeout), 32'd1);
    check("to_idle",     32'(ld_busy),     32'd0);
    check("to_halt",     32'(cpu_halt),    32'd0);
    check("to_restart2", 32'(cpu_restart), 32'd0);

    // Overflow: 256 beats with no last; beat 257 must not be accepted
    start_load(8'h00);
    check("ov_err_to_cleared", 32'(err_timeout), 32'd0);
    boundary();
    for (int i = 0; i < 256; i++) begin
      beat(8'(i) ^ 8'h5A, 1'b0, 8'(i));
    end
    check("ov_err",     32'(err_overflow), 32'd1);
    check("ov_restart", 32'(cpu_restart),  32'd1);
    ld_valid = 1'b1; ld_data = 8'hEE;
    #1;
    check("ov_ready257", 32'(ld_ready), 32'd0);
    check("ov_we257",    32'(ram_we),   32'd0);
    tick();
    check("ov_ready_idle", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    check("ov_count", 32'(ld_count), 32'h100);
    cpu_read("ov_rd00", 8'h00, 8'h5A);
    cpu_read("ov_rd80", 8'h80, 8'hDA);

    // Reset in the middle of a load
    start_load(8'h80);
    boundary();
    beat(8'hD1, 1'b0, 8'h80);
    beat(8'hD2, 1'b0, 8'h81);
    rst = 1'b1;
    tick();
    check("rl_busy",    32'(ld_busy),     32'd0);
    check("rl_halt",    32'(cpu_halt),    32'd0);
    check("rl_restart", 32'(cpu_restart), 32'd0);
    check("rl_count",   32'(ld_count),    32'd0);
    rst = 1'b0;
    tick();
    cpu_read("rl_rd80", 8'h80, 8'hD1);
    cpu_read("rl_rd81", 8'h81, 8'hD2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
